pipe_stage_skid: RTL

Parametrised pipeline stage register, the successor to the fixed-width inter-stage registers between decode, register-read, execute and memory. It carries an instruction word, a control vector and a data payload with a valid/ready handshake. A two-entry skid buffer lets upstream stall without a combinational ready path. Flush turns every held entry into a NOP bubble, an optional field override rewrites the register-address field on capture, and a saturating counter counts downstream-visible bubbles.

---
 rtl/pipe_stage_skid_if.sv | 31 +++
 rtl/pipe_stage_skid.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between a pipeline stage register and its neighbours:
// upstream beat (valid/ready + IR/ctrl/payload) and downstream beat.
interface pipe_stage_skid_if #(
    parameter int IR_W      = 16,
    parameter int CTRL_W    = 8,
    parameter int PAYLOAD_W = 96
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IR_W-1:0]      in_ir;
    logic [CTRL_W-1:0]    in_ctrl;
    logic [PAYLOAD_W-1:0] in_payload;

    logic                 out_valid;
    logic                 out_ready;
    logic [IR_W-1:0]      out_ir;
    logic [CTRL_W-1:0]    out_ctrl;
    logic [PAYLOAD_W-1:0] out_payload;

    // Environment side: drives the incoming beat and downstream ready.
    modport master (
        output in_valid, in_ir, in_ctrl, in_payload, out_ready,
        input  in_ready, out_valid, out_ir, out_ctrl, out_payload
    );

    // Stage side.
    modport slave (
        input  in_valid, in_ir, in_ctrl, in_payload, out_ready,
        output in_ready, out_valid, out_ir, out_ctrl, out_payload
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a two-entry skid buffer, flush-to-bubble,
// optional RA-field override on capture and a saturating bubble counter.
module pipe_stage_skid #(
    parameter int                   IR_W      = 16,
    parameter logic [IR_W-1:0]      NOP_IR    = 16'hF000,
    parameter int                   CTRL_W    = 8,
    parameter logic [CTRL_W-1:0]    CTRL_NOP  = 8'h00,
    parameter int                   PAYLOAD_W = 96,
    parameter int                   RA_LO     = 9,
    parameter int                   RA_W      = 3,
    parameter int                   CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    pipe_stage_skid_if.slave    bus,
    input  logic                flush,
    input  logic                mod_ra_en,
    input  logic [RA_W-1:0]     mod_ra,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    bubble_cnt,
    input  logic                cnt_clr
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    typedef enum logic [1:0] {M_HOLD, M_IN, M_SKID, M_NOP} mainSel_t;
    typedef enum logic [1:0] {S_HOLD, S_IN, S_NOP} skidSel_t;

    typedef struct packed {
        logic [IR_W-1:0]      ir;
        logic [CTRL_W-1:0]    ctrl;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    localparam entry_t NOP_ENTRY = '{ir: NOP_IR, ctrl: CTRL_NOP, payload: '0};

    state_t   state, stateNext;
    mainSel_t mainSel;
    skidSel_t skidSel;
    entry_t   mainQ, skidQ, capEntry;
    logic     accept, pop;

    assign bus.in_ready  = (state != TWO);
    assign bus.out_valid = (state != EMPTY);
    assign accept        = bus.in_valid & bus.in_ready & ~flush;
    assign pop           = bus.out_valid & bus.out_ready;

    always_comb begin
        capEntry         = '{ir: bus.in_ir, ctrl: bus.in_ctrl, payload: bus.in_payload};
        if (mod_ra_en) begin
            capEntry.ir[RA_LO +: RA_W] = mod_ra;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Flush overrides everything; a pop in that cycle needs no action because
    // downstream has already taken the head it sampled.
    always_comb begin
        stateNext = state;
        mainSel   = M_HOLD;
        skidSel   = S_HOLD;
        if (flush) begin
            stateNext = EMPTY;
            mainSel   = M_NOP;
            skidSel   = S_NOP;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        mainSel   = M_IN;
                        stateNext = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        mainSel   = M_IN;
                    end else if (accept) begin
                        skidSel   = S_IN;
                        stateNext = TWO;
                    end else if (pop) begin
                        mainSel   = M_NOP;
                        stateNext = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        mainSel   = M_SKID;
                        skidSel   = S_NOP;
                        stateNext = ONE;
                    end
                end
                default: begin
                    stateNext = EMPTY;
                    mainSel   = M_NOP;
                    skidSel   = S_NOP;
                end
            endcase
        end
    end

    // Vacated entries are refilled with the bubble so the outputs can be
    // driven straight from the main entry without gating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mainQ <= NOP_ENTRY;
            skidQ <= NOP_ENTRY;
        end else begin
            case (mainSel)
                M_IN:    mainQ <= capEntry;
                M_SKID:  mainQ <= skidQ;
                M_NOP:   mainQ <= NOP_ENTRY;
                default: mainQ <= mainQ;
            endcase
            case (skidSel)
                S_IN:    skidQ <= capEntry;
                S_NOP:   skidQ <= NOP_ENTRY;
                default: skidQ <= skidQ;
            endcase
        end
    end

    assign bus.out_ir      = mainQ.ir;
    assign bus.out_ctrl    = mainQ.ctrl;
    assign bus.out_payload = mainQ.payload;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (bus.out_ready && !bus.out_valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    // Entries not holding a live beat must always carry the bubble.
    assert property (@(posedge clk) disable iff (!reset)
                     (state == EMPTY) |-> (mainQ == NOP_ENTRY));
    assert property (@(posedge clk) disable iff (!reset)
                     (state != TWO) |-> (skidQ == NOP_ENTRY));

endmodule
